// File: rtl/req_gnt_pkg.sv
// Shared types and constants for the req/gnt initiator.
package req_gnt_pkg;

    // Width of the inter-transaction gap counter; GAP is limited to 0..15.
    localparam int GAP_W = 4;

    // Default parameter values for the initiator.
    localparam int CNT_W_DEF  = 8;
    localparam int GAP_DEF    = 0;
    localparam int STAT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GNT_HI,
        ST_GNT_LO,
        ST_GAP,
        ST_DONE
    } req_gnt_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear first, otherwise increment unless already at all-ones.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves q_d unassigned (no latch).
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/req_gnt_initiator.sv
// Requester side of the single-cycle req/gnt handshake: issues a burst of
// one-cycle req pulses and grades each returned grant shape.
module req_gnt_initiator
    import req_gnt_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GAP    = GAP_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              clear_stats,
    input  logic              gnt,
    output logic              req,
    output logic              busy,
    output logic              done,
    output logic [STAT_W-1:0] pass_cnt,
    output logic [STAT_W-1:0] fail_cnt,
    output logic              spurious_gnt
);

    // Reload value for the gap counter: it counts GAP cycles down to zero.
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    req_gnt_state_e   state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             hi_ok_q, hi_ok_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             spurious_q, spurious_d;
    logic             pass_inc;
    logic             fail_inc;

    // Next-state, transaction grading and registered-output decode.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        hi_ok_d     = hi_ok_q;
        pass_inc    = 1'b0;
        fail_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = burst_len;
                    state_d     = (burst_len != '0) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                state_d = ST_GNT_HI;
            end
            ST_GNT_HI: begin
                // Responder registers req, so the grant must be high now.
                hi_ok_d = gnt;
                state_d = ST_GNT_LO;
            end
            ST_GNT_LO: begin
                // Grant must have dropped again; exactly one counter moves.
                if (hi_ok_q && !gnt) begin
                    pass_inc = 1'b1;
                end else begin
                    fail_inc = 1'b1;
                end
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else if (GAP == 0) begin
                    state_d = ST_REQ;
                end else begin
                    gap_cnt_d = GAP_LAST;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave a flop.
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d inside {ST_REQ, ST_GNT_HI, ST_GNT_LO, ST_GAP});
        done_d = (state_d == ST_DONE);

        // Any grant outside the two expected-grant cycles is sticky-flagged.
        if (clear_stats) begin
            spurious_d = 1'b0;
        end else begin
            spurious_d = spurious_q |
                         (gnt && (state_q inside {ST_IDLE, ST_REQ, ST_GAP, ST_DONE}));
        end
    end

    // FSM, burst bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
            hi_ok_q     <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
            hi_ok_q     <= hi_ok_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            spurious_q  <= spurious_d;
        end
    end

    sat_counter #(.W(STAT_W)) u_pass_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (pass_inc),
        .clr     (clear_stats),
        .q       (pass_cnt)
    );

    sat_counter #(.W(STAT_W)) u_fail_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (fail_inc),
        .clr     (clear_stats),
        .q       (fail_cnt)
    );

    assign req          = req_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign spurious_gnt = spurious_q;

endmodule
